// File: rtl/oric_tap_player.sv
// Oric TAP image player: fetches bytes from SDRAM over a toggle handshake and
// serialises each one as an Oric K7 tape frame (start, 8 data LSB first, odd
// parity, stop bits) with a one-byte prefetch buffer between frames.
module oric_tap_player #(
  parameter int unsigned HALF_CYC  = 4992,
  parameter int unsigned STOP_BITS = 4
) (
  input  logic        clk_24,
  input  logic        reset,
  input  logic        start,
  input  logic [24:0] tap_len,
  input  logic        remote,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [24:0] mem_addr,
  input  logic [7:0]  mem_q,
  output logic        tape_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned FRAME_W = 10 + STOP_BITS;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned CNT_W   = $clog2(2 * HALF_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FRAME_HI, S_FRAME_LO, S_WAIT_BUF, S_FINISH
  } state_t;

  state_t             r_state;
  logic               r_req;
  logic               r_pend;
  logic               r_valid;
  logic [7:0]         r_buf;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_len;
  logic [FRAME_W-1:0] r_frame;
  logic [BIT_W-1:0]   r_bit;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_tape;
  logic               r_busy;
  logic               r_done;

  logic               w_rd_done;
  logic               w_buf_ok;
  logic [7:0]         w_byte;
  logic               w_more;
  logic               w_first_cyc;
  logic               w_issue;
  logic               w_hi_last;
  logic               w_lo_last;
  logic               w_last_bit;
  logic               w_frame_end;
  logic               w_load;
  logic [FRAME_W-1:0] w_new_frame;

  // A read completes when the ack catches up with our outstanding toggle
  assign w_rd_done   = r_pend && (mem_ack == r_req);
  // Next byte is available either from the buffer or straight off the bus
  assign w_buf_ok    = r_valid || w_rd_done;
  assign w_byte      = r_valid ? r_buf : mem_q;
  assign w_more      = r_valid || r_pend || (r_addr != r_len);
  assign w_first_cyc = (r_state == S_FRAME_HI) && (r_bit == '0) && (r_cnt == '0);
  // Fetch on demand, or prefetch at the very first cycle of every frame
  assign w_issue     = !r_pend && !r_valid && (r_addr != r_len) && (mem_ack == r_req) &&
                       ((r_state == S_FETCH) || (r_state == S_WAIT_BUF) || w_first_cyc);
  assign w_hi_last   = (r_cnt == CNT_W'(HALF_CYC - 1));
  assign w_lo_last   = (r_cnt == (r_frame[0] ? CNT_W'(HALF_CYC - 1) : CNT_W'(2 * HALF_CYC - 1)));
  assign w_last_bit  = (r_bit == BIT_W'(FRAME_W - 1));
  assign w_frame_end = (r_state == S_FRAME_LO) && w_lo_last && w_last_bit;
  assign w_load      = remote && w_buf_ok &&
                       ((r_state == S_FETCH) || (r_state == S_WAIT_BUF) || w_frame_end);
  // Frame shifts out LSB first: start 0, data, odd parity, stop ones
  assign w_new_frame = {{STOP_BITS{1'b1}}, ~^w_byte, w_byte, 1'b0};

  assign mem_req  = r_req;
  assign mem_addr = r_addr;
  assign tape_out = r_tape;
  assign busy     = r_busy;
  assign done     = r_done;

  // Player FSM, memory handshake, prefetch buffer and bit timing
  always_ff @(posedge clk_24) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_req   <= mem_ack;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_frame <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_tape  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_issue) begin
        r_req  <= ~r_req;
        r_pend <= 1'b1;
      end else if (!r_pend && (mem_ack != r_req)) begin
        r_req <= mem_ack;  // stray ack left over from before a reset
      end

      if (w_rd_done) begin
        r_pend <= 1'b0;
        r_addr <= r_addr + ADDR_W'(1);
        if (!w_load) begin
          r_buf   <= mem_q;
          r_valid <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_addr <= '0;
            r_len  <= tap_len;
            if (tap_len == '0) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH, S_WAIT_BUF: begin
          // waiting for a byte; the load itself is handled below
        end
        S_FRAME_HI: begin
          if (remote) begin
            if (w_hi_last) begin
              r_cnt   <= '0;
              r_state <= S_FRAME_LO;
              r_tape  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_FRAME_LO: begin
          if (remote) begin
            if (!w_lo_last) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_last_bit) begin
              r_cnt   <= '0;
              r_bit   <= r_bit + BIT_W'(1);
              r_frame <= {1'b0, r_frame[FRAME_W-1:1]};
              r_state <= S_FRAME_HI;
              r_tape  <= 1'b1;
            end else if (!w_buf_ok) begin
              if (w_more) begin
                r_cnt   <= '0;
                r_state <= S_WAIT_BUF;
                r_tape  <= 1'b0;
              end else begin
                r_state <= S_FINISH;
                r_tape  <= 1'b1;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_load) begin
        r_frame <= w_new_frame;
        r_bit   <= '0;
        r_cnt   <= '0;
        r_state <= S_FRAME_HI;
        r_tape  <= 1'b1;
        if (r_valid) r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/oric_tap_player.md
ORIC_TAP_PLAYER -- requirements
Module: oric_tap_player

Interface
REQ-001 Parameter HALF_CYC, default 4992, clk_24 cycles per short half-period (208 us).
REQ-002 Parameter STOP_BITS, default 4, number of '1' stop bits per byte frame.
REQ-003 clk_24  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins playback from address 0.
REQ-006 tap_len  input  25  byte count of the TAP image, sampled on an accepted start.
REQ-007 remote  input  1  motor enable; 1 = run, 0 = pause.
REQ-008 mem_req  output  1  toggle request to the SDRAM port.
REQ-009 mem_ack  input  1  toggle acknowledge; the request is complete when mem_ack == mem_req.
REQ-010 mem_addr  output  25  byte address of the request, stable while the request is pending.
REQ-011 mem_q  input  8  read data, valid in the cycle mem_ack becomes equal to mem_req.
REQ-012 tape_out  output  1  serial tape signal to the Oric K7 input.
REQ-013 busy  output  1  high from an accepted start until done.
REQ-014 done  output  1  one-cycle pulse when the last frame completes.

Function
REQ-015 FSM states: IDLE, FETCH, FRAME_HI, FRAME_LO, WAIT_BUF, FINISH.
REQ-016 In IDLE, start sets busy=1, sets the address to 0, latches tap_len, and goes to FETCH; start is ignored when busy=1.
REQ-017 start with tap_len=0 goes directly to FINISH, with no memory request issued.
REQ-018 FETCH: toggle mem_req once, wait for mem_ack==mem_req, load mem_q into the frame shifter, increment the address, then go to FRAME_HI.
REQ-019 Frame, sent in order: start bit 0, data bits 0..7 (LSB first), odd parity bit (data plus parity has an odd number of ones), then STOP_BITS ones.
REQ-020 Bit encoding: tape_out=1 for HALF_CYC cycles, then tape_out=0 for HALF_CYC cycles ('1') or 2*HALF_CYC cycles ('0').
REQ-021 Prefetch: at the first cycle of FRAME_HI of each frame, when bytes remain, issue the request for the next byte into a one-byte buffer with a valid flag; at most one request is outstanding.
REQ-022 At frame end, if the buffer is valid, load it and clear valid, with no gap between frames.
REQ-023 At frame end, if bytes remain but the buffer is not valid, go to WAIT_BUF: tape_out=0 until valid, then start the next frame on the following cycle.
REQ-024 At frame end, if no bytes remain, go to FINISH: done=1 for one cycle, busy=0, then IDLE.
REQ-025 remote=0 freezes the half-period counter, bit counter and FSM; tape_out holds its level; an outstanding memory request still completes into the buffer.
REQ-026 tape_out is 1 in IDLE and in FINISH.
REQ-027 Address and length compare are 25-bit; the address does not wrap, and playback stops when the address equals tap_len.

Reset
REQ-028 On reset: state=IDLE, tape_out=1, busy=0, done=0, mem_addr=0, buffer valid=0, counters=0.
REQ-029 On reset, mem_req is set to the current mem_ack, so no request is pending; a late ack toggle after reset is ignored by resyncing mem_req to mem_ack.
REQ-030 Reset mid-playback aborts immediately with no done pulse.

Verification (bench HALF_CYC=4, STOP_BITS=4, memory model acks 3 cycles after a toggle)
REQ-031 tap_len=1, byte 0x16, remote=1 -> frame bits 0,0,1,1,0,1,0,0,0,0,1,1,1,1 (parity 0); total 14*8+7*4 = 140 cycles of waveform, then a single done pulse.
REQ-032 tap_len=3, bytes 0x24,0x00,0xFF -> three back-to-back frames with no WAIT_BUF; parity bits 1,1,1; mem_addr sequence 0,1,2; exactly 3 mem_req toggles.
REQ-033 tap_len=2, memory model acks after 200 cycles -> tape_out=0 in WAIT_BUF after frame 1; frame 2 starts 1 cycle after the ack; waveform otherwise identical.
REQ-034 remote dropped for 50 cycles mid-frame -> tape_out frozen; after resume the remaining waveform is shifted by exactly 50 cycles.
REQ-035 Reset asserted during frame 2 of 3 -> next cycle tape_out=1, busy=0, no done pulse; a later start replays from address 0.
REQ-036 start with tap_len=0 -> done pulse 1 cycle later, mem_req unchanged; start while busy -> ignored.
